// File: rtl/pong_game_ctrl.sv
// Match controller for the pong datapath: scores, serve/point/game-over sequencing,
// and the re-serve/pause handshake back to the ball stage.
module pong_game_ctrl #(
    parameter int SCORE_WIDTH = 4,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60,
    parameter int POINT_DELAY = 30,
    parameter int DELAY_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic                   start,
    input  logic                   pause_btn,
    input  logic [1:0]             win,
    output logic                   ball_rst,
    output logic                   ball_pause,
    output logic [SCORE_WIDTH-1:0] score_l,
    output logic [SCORE_WIDTH-1:0] score_r,
    output logic                   game_over,
    output logic [1:0]             winner,
    output logic [2:0]             state_dbg
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        PAUSED = 3'd3,
        POINT  = 3'd4,
        OVER   = 3'd5
    } state_t;

    localparam logic [DELAY_WIDTH-1:0] SD = DELAY_WIDTH'(SERVE_DELAY);
    localparam logic [DELAY_WIDTH-1:0] PD = DELAY_WIDTH'(POINT_DELAY);
    localparam logic [SCORE_WIDTH-1:0] WS = SCORE_WIDTH'(WIN_SCORE);

    state_t                 state;
    logic [DELAY_WIDTH-1:0] cnt;
    logic                   fresh;  // first clk in the current state

    always_ff @(posedge clk) begin
        state_t nxt;
        if (rst) begin
            state     <= IDLE;
            score_l   <= '0;
            score_r   <= '0;
            game_over <= 1'b0;
            winner    <= 2'b00;
            cnt       <= '0;
            fresh     <= 1'b1;
        end else begin
            nxt = state;
            case (state)
                IDLE: if (start) nxt = SERVE;
                // Never leave SERVE on its first clk so the ball stage sees rst for >= 2 clk;
                // a final tick landing on that clk leaves cnt == SD and exits next clk.
                SERVE: if (!fresh && ((frame_tick && cnt == SD - 1'b1) || cnt == SD)) nxt = PLAY;
                PLAY: begin
                    if (!fresh && win == 2'b10) begin
                        score_l <= score_l + 1'b1;
                        nxt = POINT;
                    end else if (!fresh && win == 2'b01) begin
                        score_r <= score_r + 1'b1;
                        nxt = POINT;
                    end else if (!fresh && win == 2'b11) begin
                        nxt = SERVE;
                    end else if (pause_btn) begin
                        nxt = PAUSED;
                    end
                end
                PAUSED: if (pause_btn) nxt = PLAY;
                POINT: if (frame_tick && cnt == PD - 1'b1) begin
                    if (score_l == WS) begin
                        winner    <= 2'b10;
                        game_over <= 1'b1;
                        nxt = OVER;
                    end else if (score_r == WS) begin
                        winner    <= 2'b01;
                        game_over <= 1'b1;
                        nxt = OVER;
                    end else begin
                        nxt = SERVE;
                    end
                end
                OVER: if (start) begin
                    score_l   <= '0;
                    score_r   <= '0;
                    game_over <= 1'b0;
                    winner    <= 2'b00;
                    nxt = SERVE;
                end
                default: nxt = IDLE;
            endcase
            // A tick coinciding with a transition belongs to the old state only.
            if (nxt != state) begin
                cnt   <= '0;
                fresh <= 1'b1;
            end else begin
                fresh <= 1'b0;
                if (frame_tick) cnt <= cnt + 1'b1;
            end
            state <= nxt;
        end
    end

    assign ball_rst   = (state == IDLE) || (state == SERVE) || (state == OVER);
    assign ball_pause = (state == IDLE) || (state == PAUSED) || (state == POINT) || (state == OVER);
    assign state_dbg  = state;
endmodule
